// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard-control block: scoreboard entry layout,
// the regfile forward-select code and the forward-select width function.
package hazard_pkg;

  // Scoreboard rd field is sized for the widest supported register file; narrower
  // addresses are zero-extended on entry and on compare.
  localparam int SB_RD_W = 8;
  localparam int FWD_RF  = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               reg_wr;
    logic               is_load;
  } sb_entry_t;

  function automatic int fwd_sel_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-side hazard interface: decode fields and branch resolve in, forward selects,
// stall/flush and performance counters out. Purely combinational wiring, no handshake.
interface hazard_unit_if #(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  import hazard_pkg::*;

  localparam int SEL_W = fwd_sel_w(DEPTH);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_wr;
  logic              id_is_load;
  logic              ex_br_taken;
  logic [SEL_W-1:0]  fwd_sel_a;
  logic [SEL_W-1:0]  fwd_sel_b;
  logic              stall;
  logic              flush;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_wr, id_is_load, ex_br_taken,
    input  fwd_sel_a, fwd_sel_b, stall, flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_wr, id_is_load, ex_br_taken,
    output fwd_sel_a, fwd_sel_b, stall, flush, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// DEPTH-entry destination shift register plus youngest-match encoder per source.
// Match outputs are combinational from registered entries; entries shift every cycle.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  localparam int SEL_W = fwd_sel_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_wr,
  input  logic              id_is_load,
  input  logic [REG_AW-1:0] rs1,
  input  logic              rs1_used,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs2_used,
  output logic [SEL_W-1:0]  sel_a,
  output logic              load_a,
  output logic [SEL_W-1:0]  sel_b,
  output logic              load_b
);

  sb_entry_t sb [1:DEPTH];
  sb_entry_t new_entry;

  function automatic logic hit(input sb_entry_t e, input logic [REG_AW-1:0] src,
                               input logic used);
    return used && (src != '0) && e.valid && e.reg_wr && (e.rd == SB_RD_W'(src));
  endfunction

  always_comb begin
    new_entry = '0;
    if (issue) begin
      new_entry.valid   = 1'b1;
      new_entry.rd      = SB_RD_W'(id_rd);
      new_entry.reg_wr  = id_reg_wr;
      new_entry.is_load = id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) sb[k] <= '0;
    end else begin
      sb[1] <= new_entry;
      for (int k = 2; k <= DEPTH; k++) sb[k] <= sb[k-1];
    end
  end

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    sel_a  = SEL_W'(FWD_RF);
    load_a = 1'b0;
    sel_b  = SEL_W'(FWD_RF);
    load_b = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (hit(sb[k], rs1, rs1_used)) begin
        sel_a  = SEL_W'(k);
        load_a = sb[k].is_load;
      end
      if (hit(sb[k], rs2, rs2_used)) begin
        sel_b  = SEL_W'(k);
        load_b = sb[k].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: forwarding selects, load-use stall, branch flush, counters.
// Selects/stall/flush are same-cycle combinational; flush always overrides stall.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int BR_PENALTY = 2,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_unit_if.slave  hz
);

  localparam int SEL_W = fwd_sel_w(DEPTH);
  localparam int FL_W  = (BR_PENALTY > 1) ? $clog2(BR_PENALTY) : 1;

  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic             load_a;
  logic             load_b;
  logic             load_use;
  logic             stall;
  logic             flush;
  logic             issue;
  logic [FL_W-1:0]  flush_left;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  hazard_scoreboard #(
    .DEPTH  (DEPTH),
    .REG_AW (REG_AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .id_rd      (hz.id_rd),
    .id_reg_wr  (hz.id_reg_wr),
    .id_is_load (hz.id_is_load),
    .rs1        (hz.id_rs1),
    .rs1_used   (hz.id_rs1_used),
    .rs2        (hz.id_rs2),
    .rs2_used   (hz.id_rs2_used),
    .sel_a      (sel_a),
    .load_a     (load_a),
    .sel_b      (sel_b),
    .load_b     (load_b)
  );

  // Load data is not available until it reaches LOAD_STAGE, so a younger match must wait.
  always_comb begin
    load_use = (load_a && (int'(sel_a) < LOAD_STAGE)) ||
               (load_b && (int'(sel_b) < LOAD_STAGE));
    flush    = hz.ex_br_taken || (flush_left != '0);
    stall    = hz.id_valid && !flush && load_use;
    issue    = hz.id_valid && !stall && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_left <= '0;
    end else if (hz.ex_br_taken) begin
      flush_left <= FL_W'(BR_PENALTY - 1);
    end else if (flush_left != '0) begin
      flush_left <= flush_left - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.fwd_sel_a = sel_a;
  assign hz.fwd_sel_b = sel_b;
  assign hz.stall     = stall;
  assign hz.flush     = flush;
  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a default-parameter instance driven from a per-cycle
// vector table, and a DEPTH=5/LOAD_STAGE=4 instance for long stalls and mid-stall reset.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  hazard_unit_if #(.DEPTH(3), .REG_AW(5), .CNT_W(32)) ifa ();
  hazard_unit_if #(.DEPTH(5), .REG_AW(5), .CNT_W(32)) ifb ();

  hazard_unit #(
    .DEPTH(3), .LOAD_STAGE(2), .BR_PENALTY(2), .REG_AW(5), .CNT_W(32)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .hz  (ifa)
  );

  hazard_unit #(
    .DEPTH(5), .LOAD_STAGE(4), .BR_PENALTY(2), .REG_AW(5), .CNT_W(32)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .hz  (ifb)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       br;
    int         e_sel_a;
    int         e_sel_b;
    int         e_stall;
    int         e_flush;
    int         e_scnt;
    int         e_fcnt;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  int tests = 0;
  int fails = 0;

  function automatic vec_t v(input logic valid, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                             input logic wr, input logic ld, input logic br,
                             input int esa, input int esb, input int est, input int efl,
                             input int escnt, input int efcnt);
    vec_t t;
    t.valid = valid; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
    t.rd = rd; t.wr = wr; t.ld = ld; t.br = br;
    t.e_sel_a = esa; t.e_sel_b = esb; t.e_stall = est; t.e_flush = efl;
    t.e_scnt = escnt; t.e_fcnt = efcnt;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t t);
    ifa.id_valid    = t.valid;
    ifa.id_rs1      = t.rs1;
    ifa.id_rs1_used = t.u1;
    ifa.id_rs2      = t.rs2;
    ifa.id_rs2_used = t.u2;
    ifa.id_rd       = t.rd;
    ifa.id_reg_wr   = t.wr;
    ifa.id_is_load  = t.ld;
    ifa.ex_br_taken = t.br;
  endtask

  task automatic drive_b(input logic valid, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rd, input logic wr, input logic ld);
    ifb.id_valid    = valid;
    ifb.id_rs1      = rs1;
    ifb.id_rs1_used = u1;
    ifb.id_rs2      = 5'd0;
    ifb.id_rs2_used = 1'b0;
    ifb.id_rd       = rd;
    ifb.id_reg_wr   = wr;
    ifb.id_is_load  = ld;
    ifb.ex_br_taken = 1'b0;
  endtask

  task automatic chk_b(input string name, input int idx, input int esel, input int est,
                       input int escnt);
    chk({name, ".sel_a"}, idx, 64'(ifb.fwd_sel_a), 64'(esel));
    chk({name, ".stall"}, idx, 64'(ifb.stall), 64'(est));
    chk({name, ".stall_cnt"}, idx, 64'(ifb.stall_cnt), 64'(escnt));
  endtask

  initial begin
    // Per-cycle vectors for the default instance; counters are values seen in that cycle.
    //             vld rs1 u1 rs2 u2 rd wr ld br  sa sb st fl sc fc
    vecs[0]  = v(1,  1, 0,  0, 0,  5, 1, 0, 0,  0, 0, 0, 0, 0, 0); // addi x5
    vecs[1]  = v(1,  5, 1,  5, 1,  6, 1, 0, 0,  1, 1, 0, 0, 0, 0); // add x6,x5,x5
    vecs[2]  = v(1,  5, 1,  5, 0, 10, 0, 0, 0,  2, 0, 0, 0, 0, 0); // rs2 unused
    vecs[3]  = v(1,  5, 1,  6, 1, 10, 0, 0, 0,  3, 2, 0, 0, 0, 0);
    vecs[4]  = v(1,  5, 1,  6, 1, 10, 0, 0, 0,  0, 3, 0, 0, 0, 0); // x5 retired
    vecs[5]  = v(1,  1, 1,  0, 0,  7, 1, 1, 0,  0, 0, 0, 0, 0, 0); // lw x7
    vecs[6]  = v(1,  7, 1,  0, 1,  8, 1, 0, 0,  1, 0, 1, 0, 0, 0); // add x8,x7,x0
    vecs[7]  = v(1,  7, 1,  0, 1,  8, 1, 0, 0,  2, 0, 0, 0, 1, 0);
    vecs[8]  = v(1,  0, 0,  0, 0,  9, 1, 0, 0,  0, 0, 0, 0, 1, 0); // x9 writer
    vecs[9]  = v(1,  0, 0,  0, 0, 11, 1, 0, 0,  0, 0, 0, 0, 1, 0); // x11 writer
    vecs[10] = v(1,  0, 0,  0, 0,  9, 1, 0, 0,  0, 0, 0, 0, 1, 0); // x9 writer again
    vecs[11] = v(1,  9, 1, 11, 1,  0, 0, 0, 0,  1, 2, 0, 0, 1, 0);
    vecs[12] = v(1,  0, 0,  0, 0,  0, 1, 1, 0,  0, 0, 0, 0, 1, 0); // load to x0
    vecs[13] = v(1,  0, 1,  0, 1,  0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    vecs[14] = v(1,  0, 0,  0, 0, 12, 1, 0, 1,  0, 0, 0, 1, 1, 0); // taken branch
    vecs[15] = v(1,  0, 0,  0, 0, 12, 1, 0, 0,  0, 0, 0, 1, 1, 1);
    vecs[16] = v(1, 12, 1,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1, 2); // x12 never issued
    vecs[17] = v(0,  0, 0,  0, 0,  0, 0, 0, 1,  0, 0, 0, 1, 1, 2);
    vecs[18] = v(0,  0, 0,  0, 0,  0, 0, 0, 1,  0, 0, 0, 1, 1, 3); // reload
    vecs[19] = v(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 1, 4);
    vecs[20] = v(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1, 5);
    vecs[21] = v(1,  1, 1,  0, 0, 13, 1, 1, 0,  0, 0, 0, 0, 1, 5); // lw x13
    vecs[22] = v(1, 13, 1,  0, 0, 14, 1, 0, 1,  1, 0, 0, 1, 1, 5); // load-use + branch
    vecs[23] = v(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 1, 6);
    vecs[24] = v(1, 14, 1, 13, 1,  0, 0, 0, 0,  0, 3, 0, 0, 1, 7);
    vecs[25] = v(1,  1, 1,  0, 0, 15, 1, 1, 0,  0, 0, 0, 0, 1, 7); // lw x15
    vecs[26] = v(0, 15, 1,  0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 1, 7); // no instr: no stall

    drive_a(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive_b(0, 5'd0, 0, 5'd0, 0, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst.a.sel_a", 0, 64'(ifa.fwd_sel_a), 64'd0);
    chk("rst.a.sel_b", 0, 64'(ifa.fwd_sel_b), 64'd0);
    chk("rst.a.stall", 0, 64'(ifa.stall), 64'd0);
    chk("rst.a.flush", 0, 64'(ifa.flush), 64'd0);
    chk("rst.a.stall_cnt", 0, 64'(ifa.stall_cnt), 64'd0);
    chk("rst.a.flush_cnt", 0, 64'(ifa.flush_cnt), 64'd0);
    chk("rst.b.flush_cnt", 0, 64'(ifb.flush_cnt), 64'd0);

    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive_a(vecs[i]);
      #2;
      chk("vec.sel_a", i, 64'(ifa.fwd_sel_a), 64'(vecs[i].e_sel_a));
      chk("vec.sel_b", i, 64'(ifa.fwd_sel_b), 64'(vecs[i].e_sel_b));
      chk("vec.stall", i, 64'(ifa.stall), 64'(vecs[i].e_stall));
      chk("vec.flush", i, 64'(ifa.flush), 64'(vecs[i].e_flush));
      chk("vec.stall_cnt", i, 64'(ifa.stall_cnt), 64'(vecs[i].e_scnt));
      chk("vec.flush_cnt", i, 64'(ifa.flush_cnt), 64'(vecs[i].e_fcnt));
      @(negedge clk);
    end

    // Reset in the middle of a flush sequence leaves no residual flush cycle.
    drive_a(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    #2;
    chk("rstflush.flush", 0, 64'(ifa.flush), 64'd1);
    @(negedge clk);
    drive_a(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_a = 1'b1;
    #2;
    chk("rstflush.flush", 1, 64'(ifa.flush), 64'd1);
    @(negedge clk);
    rst_a = 1'b0;
    #2;
    chk("rstflush.flush", 2, 64'(ifa.flush), 64'd0);
    chk("rstflush.flush_cnt", 2, 64'(ifa.flush_cnt), 64'd0);
    chk("rstflush.stall_cnt", 2, 64'(ifa.stall_cnt), 64'd0);

    // DEPTH=5, LOAD_STAGE=4: a back-to-back dependent load stalls three cycles.
    @(negedge clk);
    drive_b(1, 5'd1, 1, 5'd7, 1, 1);
    #2;
    chk_b("deep", 0, 0, 0, 0);
    @(negedge clk);
    drive_b(1, 5'd7, 1, 5'd8, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      #2;
      chk_b("deep.stall", k, k, 1, k - 1);
      @(negedge clk);
    end
    #2;
    chk_b("deep.fwd", 4, 4, 0, 3);
    @(negedge clk);
    drive_b(0, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clk);

    // Same hazard again, with reset asserted in the second stall cycle.
    drive_b(1, 5'd1, 1, 5'd7, 1, 1);
    @(negedge clk);
    drive_b(1, 5'd7, 1, 5'd8, 1, 0);
    #2;
    chk_b("deeprst", 1, 1, 1, 3);
    @(negedge clk);
    rst_b = 1'b1;
    #2;
    chk_b("deeprst", 2, 2, 1, 4);
    @(negedge clk);
    rst_b = 1'b0;
    #2;
    chk_b("deeprst", 3, 0, 0, 0);
    chk("deeprst.flush_cnt", 3, 64'(ifb.flush_cnt), 64'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
